uart_rx_mmio: RTL and testbench
===============================

Name: uart_rx_mmio

Overview:
Memory-mapped UART receiver peripheral for the pipelined RISC-V core. It deserializes the off-chip uart_rx line (8N1, LSB first) and buffers received bytes in a small FIFO. The data path's MEM-stage load/store logic reads and pops bytes and reads and clears status. It sits directly upstream of the core's data path load path, feeding it.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz.
BAUD_RATE, 115200, serial bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division), must be >= 4.
FIFO_DEPTH, 4, receive FIFO entries. Must be a power of 2, >= 2.
DATA_WIDTH, 32, width of the bus read/write data.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
uart_rx  input  1  asynchronous serial input; idles high.
sel  input  1  peripheral selected by the MEM-stage address decode.
addr  input  1  register select: 0 = RXDATA, 1 = STATUS.
rd_en  input  1  load access this cycle (qualified by sel).
wr_en  input  1  store access this cycle (qualified by sel).
wdata  input  DATA_WIDTH  store data; only bits [2:1] are used.
rdata  output  DATA_WIDTH  combinational read data.
rx_irq  output  1  registered; high when the FIFO is not empty.

Behaviour:
- Reset: the clock is named clk and the reset is named reset; reset is synchronous and active-high.
  - Synchronizer flops reset to 1.
  - FSM resets to IDLE; bit counter, sample counter and shift register reset to 0.
  - FIFO pointers and count reset to 0; overrun and frame_err reset to 0.
  - rx_irq resets to 0.
  - A reset mid-frame discards the partial byte and all FIFO contents.
- Input sync: two-flop synchronizer on uart_rx, giving rx_s. The FSM sees only rx_s (2-cycle latency).
- FSM states:
  - IDLE: when rx_s = 0, load the sample counter with CLKS_PER_BIT/2 - 1 and go to START.
  - START: when the counter reaches 0, sample rx_s. If rx_s = 0, reload the counter with CLKS_PER_BIT - 1, clear the bit index and go to DATA. If rx_s = 1 (glitch), go to IDLE with no side effects.
  - DATA: when the counter reaches 0, shift rx_s into bit[bit_index] (LSB first) and reload the counter.
    - After bit 7, go to STOP.
    - Sampling is mid-bit.
  - STOP: when the counter reaches 0, sample rx_s.
    - If rx_s = 1: push the byte and go to IDLE.
    - If rx_s = 0: set frame_err, discard the byte and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s = 1, then go to IDLE. This prevents a break condition from being decoded as frames.
- FIFO push:
  - The byte is written on the cycle of the stop-bit sample and is visible in rdata/status the following cycle.
  - If the FIFO is full and there is no simultaneous pop, the byte is dropped, overrun is set and the FIFO is unchanged.
  - If full with a simultaneous pop, both happen and count is unchanged.
  - Push and pop on a non-full, non-empty FIFO: count is unchanged.
- Pop: occurs when sel & rd_en & addr = 0 & count != 0, on the clock edge.
  - A read of RXDATA while empty returns 0 and does not move the pointers or change the flags.
  - Pointers wrap modulo FIFO_DEPTH.
- rdata (combinational, 0 when sel = 0 or rd_en = 0):
  - addr 0: {24'b0, head byte}, or 0 if empty.
  - addr 1: bit0 = not_empty, bit1 = overrun, bit2 = frame_err, bit3 = full, other bits 0.
- Write: sel & wr_en & addr = 1 clears overrun where wdata[1] = 1 and frame_err where wdata[2] = 1 (write-1-to-clear).
  - If a set event and a clear occur in the same cycle, the set wins.
  - Writes to addr 0 are ignored.
- rx_irq = registered (count != 0), i.e. one cycle after the count changes.
- rd_en and wr_en both high in the same cycle: both actions are performed independently.

Test Plan:
All scenarios use CLK_FREQ=1600000 and BAUD_RATE=100000, giving CLKS_PER_BIT=16.
- Reset then idle line high: rdata(addr1) = 0x0 and rx_irq = 0 for 100 cycles. Assert reset mid-frame: after reset, status = 0x0 and no byte is pushed.
- Send 0xA5 as a frame (start, 1,0,1,0,0,1,0,1, stop):
  - status = 0x1 one cycle after the stop-bit sample; rx_irq follows one cycle later.
  - Read addr0 returns 0x000000A5 and pops; the next status read returns 0x0.
- Send 0x11, 0x22, 0x33, 0x44, 0x55 with no reads:
  - status = 0xB (not_empty, overrun, full).
  - Reads return 0x11, 0x22, 0x33, 0x44, then 0x0.
  - Write 0x2 to addr1: overrun clears and status = 0x0.
- Stop bit driven 0 for 0x3C, line held low for 40 bit-times, then released:
  - frame_err set (status = 0x4) and FIFO empty.
  - No further frames are decoded until the line is high.
  - A following 0x7E frame is received correctly.
- 4-cycle low glitch on idle uart_rx: FSM returns to IDLE with no push and no flags set.
- FIFO full (0x01..0x04) with a pop of RXDATA on the exact cycle of the 0x05 stop-bit sample:
  - No overrun.
  - Subsequent reads return 0x02, 0x03, 0x04, 0x05.

Source files
------------

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio
// Memory-mapped UART receiver (8N1, LSB first) with a small receive FIFO,
// read by the core's MEM-stage load/store path.
//
// Ports:
//   clk      system clock, all logic on the rising edge
//   reset    synchronous active-high reset
//   uart_rx  asynchronous serial input, idles high
//   sel      peripheral selected by the MEM-stage address decode
//   addr     register select: 0 = RXDATA, 1 = STATUS
//   rd_en    load access (qualified by sel); RXDATA loads pop the FIFO
//   wr_en    store access (qualified by sel); STATUS stores are write-1-to-clear
//   wdata    store data, bit1 clears overrun, bit2 clears frame_err
//   rdata    combinational read data
//   rx_irq   registered, high while the FIFO holds data
//
// STATUS layout: bit0 not_empty, bit1 overrun, bit2 frame_err, bit3 full.
module uart_rx_mmio #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_rx,
  input  logic                  sel,
  input  logic                  addr,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rx_irq
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int FCNT_W       = PTR_W + 1;

  // Start-bit wait lands the first sample mid-bit; later samples are a full bit apart.
  localparam logic [CNT_W-1:0]  HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_ONE    = FCNT_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_FULL   = FCNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE     = PTR_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  logic             rx_sync_p0;
  logic             rx_s;
  state_t           state;
  logic [CNT_W-1:0] sample_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FCNT_W-1:0] count;
  logic              overrun;
  logic              frame_err;

  logic sample_now;
  logic stop_ok;
  logic stop_bad;
  logic not_empty;
  logic full;
  logic pop;
  logic push;
  logic overrun_set;
  logic status_wr;

  logic unused_wdata;
  assign unused_wdata = ^{wdata[DATA_WIDTH-1:3], wdata[0]};

  // ---- input synchronizer: uart_rx -> rx_sync_p0 -> rx_s ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_sync_p0 <= uart_rx;
      rx_s       <= rx_sync_p0;
    end
  end

  // ---- receive FSM: bit timing and deserialization ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            sample_cnt <= HALF_RELOAD;
            state      <= START;
          end
        end
        START: begin
          if (sample_cnt == '0) begin
            // A line already back high at mid start bit was only a glitch.
            if (!rx_s) begin
              sample_cnt <= BIT_RELOAD;
              bit_idx    <= '0;
              state      <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            sample_cnt <= sample_cnt - CNT_ONE;
          end
        end
        DATA: begin
          if (sample_cnt == '0) begin
            shift_reg[bit_idx] <= rx_s;
            sample_cnt         <= BIT_RELOAD;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            sample_cnt <= sample_cnt - CNT_ONE;
          end
        end
        STOP: begin
          if (sample_cnt == '0) begin
            state <= rx_s ? IDLE : WAIT_HIGH;
          end else begin
            sample_cnt <= sample_cnt - CNT_ONE;
          end
        end
        WAIT_HIGH: begin
          // Hold off decoding until a break releases the line.
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sample_now  = (state == STOP) && (sample_cnt == '0);
  assign stop_ok     = sample_now && rx_s;
  assign stop_bad    = sample_now && !rx_s;

  assign not_empty   = (count != '0);
  assign full        = (count == FCNT_FULL);
  assign pop         = sel && rd_en && !addr && not_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push        = stop_ok && (!full || pop);
  assign overrun_set = stop_ok && full && !pop;
  assign status_wr   = sel && wr_en && addr;

  // ---- receive FIFO and status flags ----
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= shift_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rx_irq    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + FCNT_ONE;
        2'b01:   count <= count - FCNT_ONE;
        default: count <= count;
      endcase
      // Set events take priority over a same-cycle write-1-to-clear.
      overrun   <= overrun_set || (overrun && !(status_wr && wdata[1]));
      frame_err <= stop_bad || (frame_err && !(status_wr && wdata[2]));
      rx_irq    <= not_empty;
    end
  end

  // ---- bus read mux ----
  always_comb begin
    rdata = '0;
    if (sel && rd_en) begin
      if (!addr) begin
        if (not_empty) begin
          rdata = {{(DATA_WIDTH - 8){1'b0}}, fifo_mem[rd_ptr]};
        end
      end else begin
        rdata = DATA_WIDTH'({full, frame_err, overrun, not_empty});
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
module tb_uart_rx_mmio;

  localparam int CLK_FREQ  = 1600000;
  localparam int BAUD_RATE = 100000;
  localparam int CPB       = 16;
  localparam int DEPTH     = 4;
  localparam int DW        = 32;

  logic          clk;
  logic          reset;
  logic          uart_rx;
  logic          sel;
  logic          addr;
  logic          rd_en;
  logic          wr_en;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rx_irq;

  uart_rx_mmio #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .FIFO_DEPTH(DEPTH),
    .DATA_WIDTH(DW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .uart_rx(uart_rx),
    .sel    (sel),
    .addr   (addr),
    .rd_en  (rd_en),
    .wr_en  (wr_en),
    .wdata  (wdata),
    .rdata  (rdata),
    .rx_irq (rx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: received bytes in arrival order plus the two sticky flags.
  logic [7:0] mq[$];
  bit         m_ovr;
  bit         m_fe;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic ne;
    logic fl;
    ne = (mq.size() != 0);
    fl = (mq.size() == DEPTH);
    return {28'b0, fl, m_fe, m_ovr, ne};
  endfunction

  function automatic void model_rx(input logic [7:0] b, input bit stop);
    if (!stop) m_fe = 1'b1;
    else if (mq.size() == DEPTH) m_ovr = 1'b1;
    else mq.push_back(b);
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    idle(CPB);
  endtask

  task automatic send_head(input logic [7:0] b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    send_head(b);
    drive_bit(stop);
    model_rx(b, stop);
  endtask

  task automatic bus_read(input logic a, output logic [31:0] d);
    sel   = 1'b1;
    addr  = a;
    rd_en = 1'b1;
    #1 d = rdata;
    @(posedge clk);
    #1;
    sel   = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic bus_write(input logic a, input logic [31:0] v);
    sel   = 1'b1;
    addr  = a;
    wr_en = 1'b1;
    wdata = v;
    @(posedge clk);
    #1;
    sel   = 1'b0;
    wr_en = 1'b0;
    wdata = '0;
    if (a) begin
      if (v[1]) m_ovr = 1'b0;
      if (v[2]) m_fe = 1'b0;
    end
  endtask

  task automatic read_data(input string tag);
    logic [31:0] d;
    logic [31:0] exp;
    bus_read(1'b0, d);
    if (mq.size() != 0) exp = {24'b0, mq.pop_front()};
    else exp = '0;
    chk(tag, d, exp);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    bus_read(1'b1, d);
    chk(tag, d, model_status());
    chk({tag, "_irq"}, {31'b0, rx_irq}, {31'b0, mq.size() != 0});
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          bad;
    logic [7:0]  rb;
    bit          rstop;

    uart_rx = 1'b1;
    sel     = 1'b0;
    addr    = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    wdata   = '0;
    reset   = 1'b1;
    m_ovr   = 1'b0;
    m_fe    = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and a quiet idle line
    check_status("reset");
    bad = 0;
    sel = 1'b1; addr = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      idle(1);
      if (rdata !== 32'h0 || rx_irq !== 1'b0) bad++;
    end
    sel = 1'b0; rd_en = 1'b0;
    chk("idle_bad_cycles", bad, 0);

    // Reset mid-frame drops the FIFO and the partial byte
    send_frame(8'h5A, 1'b1);
    check_status("pre_rst");
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    uart_rx = 1'b1;
    reset   = 1'b1;
    idle(3);
    reset = 1'b0;
    mq.delete();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
    idle(200);
    check_status("rst_mid");

    // 0xA5 with exact push / irq timing: stop sample 155 cycles after start edge
    send_head(8'hA5);
    uart_rx = 1'b1;
    sel = 1'b1; addr = 1'b1; rd_en = 1'b1;
    idle(10);
    chk("a5_before_push", rdata, 32'h0);
    idle(1);
    chk("a5_after_push", rdata, 32'h1);
    chk("a5_irq_lag", {31'b0, rx_irq}, 32'h0);
    idle(1);
    chk("a5_irq", {31'b0, rx_irq}, 32'h1);
    sel = 1'b0; rd_en = 1'b0;
    model_rx(8'hA5, 1'b1);
    idle(3);
    read_data("a5_data");
    check_status("a5_empty");

    // Overrun: five frames into a four-entry FIFO
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    send_frame(8'h55, 1'b1);
    check_status("ovr_full");
    for (int i = 0; i < 5; i++) read_data("ovr_data");
    bus_write(1'b0, 32'h6);
    check_status("wr_addr0_ignored");
    bus_write(1'b1, 32'h2);
    check_status("ovr_clear");

    // Bad stop bit followed by a 40 bit-time break
    send_frame(8'h3C, 1'b0);
    check_status("break_start");
    idle(40 * CPB);
    check_status("break_end");
    uart_rx = 1'b1;
    idle(3 * CPB);
    check_status("break_release");
    send_frame(8'h7E, 1'b1);
    check_status("after_break");
    read_data("after_break_data");
    bus_write(1'b1, 32'h4);
    check_status("fe_clear");

    // Short low glitch is ignored, and the receiver still works afterwards
    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(50);
    check_status("glitch");
    send_frame(8'h96, 1'b1);
    read_data("post_glitch_data");

    // Full FIFO with a pop on the same edge as the 0x05 stop-bit sample
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    send_frame(8'h04, 1'b1);
    send_head(8'h05);
    uart_rx = 1'b1;
    idle(10);
    bus_read(1'b0, d);
    chk("same_cycle_pop", d, {24'b0, mq.pop_front()});
    mq.push_back(8'h05);
    idle(5);
    check_status("same_cycle_status");
    for (int i = 0; i < 4; i++) read_data("same_cycle_data");
    check_status("same_cycle_empty");

    // Randomized frames, bad stops and bus traffic against the model
    for (int it = 0; it < 30; it++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 7) != 0);
      send_frame(rb, rstop);
      if (!rstop) begin
        idle($urandom_range(1, 3) * CPB);
        uart_rx = 1'b1;
        idle(CPB);
      end else begin
        idle($urandom_range(0, 20));
      end
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        case ($urandom_range(0, 3))
          0, 1:    read_data("rand_data");
          2:       check_status("rand_status");
          default: bus_write(1'b1, $urandom);
        endcase
      end
    end
    check_status("rand_final");
    while (mq.size() != 0) read_data("rand_drain");
    check_status("rand_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
